multicycle_control: RTL and testbench

- Moore/Mealy FSM that sequences the multicycle MIPS datapath: one shared memory, one ALU, and IR/A/B/ALUOut/MDR registers.
- Decodes the opcode from the IR and steps through fetch, decode, execute, memory and writeback.
- Drives every datapath mux/enable each cycle and stalls on a memory-ready handshake.
- A bounded wait counter flags memory timeouts.

---
 rtl/multicycle_control_if.sv | 37 +++
 rtl/multicycle_control.sv | 175 +++++++++++++++++
 tb/tb_multicycle_control.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle MIPS controller and its datapath.
// The controller drives the datapath controls; the datapath returns the opcode and the memory-ready strobe.
interface multicycle_control_if;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNE;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MemToReg;
  logic       RegDst;
  logic       RegWrite;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic [3:0] State;
  logic       Illegal;
  logic       MemTimeout;

  modport master (
    input  Op, MemReady,
    output PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           State, Illegal, MemTimeout
  );

  modport slave (
    output Op, MemReady,
    input  PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
           MemToReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           State, Illegal, MemTimeout
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// stalls on MemReady and aborts to IDLE when a memory wait exceeds WAIT_LIMIT.
module multicycle_control #(
  parameter int WAIT_LIMIT = 15,
  parameter int CNT_W      = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  multicycle_control_if.master   bus
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_MEMADR = 4'd3,
    S_MEMRD  = 4'd4,
    S_MEMWB  = 4'd5,
    S_MEMWR  = 4'd6,
    S_EXEC   = 4'd7,
    S_RWB    = 4'd8,
    S_BRANCH = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_J    = 6'd2;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;

  localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(WAIT_LIMIT);
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'((WAIT_LIMIT > 0) ? WAIT_LIMIT - 1 : 0);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_illegal;
  logic             r_timeout;
  logic             w_wait;
  logic             w_tmo;
  logic             w_bad_op;

  // Only the three memory-handshake states can stall.
  assign w_wait = ((r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR))
                  && !bus.MemReady;
  assign w_tmo  = (WAIT_LIMIT > 0) && w_wait && (r_cnt == LIMIT_M1);

  always_comb begin
    w_bad_op = 1'b0;
    w_next   = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = bus.MemReady ? S_DECODE : (w_tmo ? S_IDLE : S_FETCH);
      S_DECODE: begin
        case (bus.Op)
          OP_R:           w_next = S_EXEC;
          OP_LW, OP_SW:   w_next = S_MEMADR;
          OP_BEQ, OP_BNE: w_next = S_BRANCH;
          OP_ADDI:        w_next = S_ADDIEX;
          OP_J:           w_next = S_JUMP;
          default: begin
            w_next   = S_FETCH;
            w_bad_op = 1'b1;
          end
        endcase
      end
      S_MEMADR: w_next = (bus.Op == OP_LW) ? S_MEMRD : ((bus.Op == OP_SW) ? S_MEMWR : S_FETCH);
      S_MEMRD:  w_next = bus.MemReady ? S_MEMWB : (w_tmo ? S_IDLE : S_MEMRD);
      S_MEMWB:  w_next = S_FETCH;
      S_MEMWR:  w_next = bus.MemReady ? S_FETCH : (w_tmo ? S_IDLE : S_MEMWR);
      S_EXEC:   w_next = S_RWB;
      S_RWB:    w_next = S_FETCH;
      S_BRANCH: w_next = S_FETCH;
      S_ADDIEX: w_next = S_ADDIWB;
      S_ADDIWB: w_next = S_FETCH;
      S_JUMP:   w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_illegal <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= w_bad_op;
      r_timeout <= w_tmo;
      if (w_next != r_state)
        r_cnt <= '0;
      else if (w_wait && (r_cnt != LIMIT))
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // Moore decode from the state register; IRWrite/PCWrite in FETCH follow MemReady.
  always_comb begin
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNE    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 2'b00;
    bus.ALUOp       = 2'b00;
    bus.PCSource    = 2'b00;
    case (r_state)
      S_FETCH: begin
        bus.MemRead = 1'b1;
        bus.ALUSrcB = 2'b01;
        bus.IRWrite = bus.MemReady;
        bus.PCWrite = bus.MemReady;
      end
      S_DECODE: bus.ALUSrcB = 2'b11;
      S_MEMADR: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        bus.MemRead = 1'b1;
        bus.IorD    = 1'b1;
      end
      S_MEMWB: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
      end
      S_MEMWR: begin
        bus.MemWrite = 1'b1;
        bus.IorD     = 1'b1;
      end
      S_EXEC: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUOp   = 2'b10;
      end
      S_RWB: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
      end
      S_BRANCH: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 2'b01;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 2'b01;
        bus.BranchNE    = (bus.Op == OP_BNE);
      end
      S_ADDIEX: begin
        bus.ALUSrcA = 1'b1;
        bus.ALUSrcB = 2'b10;
      end
      S_ADDIWB: bus.RegWrite = 1'b1;
      S_JUMP: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 2'b10;
      end
      default: ;
    endcase
  end

  assign bus.State      = r_state;
  assign bus.Illegal    = r_illegal;
  assign bus.MemTimeout = r_timeout;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: each instruction is expanded into its expected
// per-cycle state trace, the trace drives MemReady, and every cycle is checked.
module tb_multicycle_control;
  localparam int WL = 15;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEMADR = 4'd3,
                         S_MEMRD = 4'd4, S_MEMWB = 4'd5, S_MEMWR = 4'd6, S_EXEC = 4'd7,
                         S_RWB = 4'd8, S_BRANCH = 4'd9, S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
                         S_JUMP = 4'd12;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  multicycle_control_if bus();

  multicycle_control #(.WAIT_LIMIT(WL), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] st;
    logic [5:0] op;
    logic       mr;
    logic       ill;
    logic       tmo;
  } step_t;

  step_t q[$];
  logic  pend_ill = 1'b0;

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic void push(input logic [3:0] st, input logic [5:0] op,
                               input logic mr, input logic tmo);
    step_t s;
    s.st = st; s.op = op; s.mr = mr; s.ill = pend_ill; s.tmo = tmo;
    pend_ill = 1'b0;
    q.push_back(s);
  endfunction

  // w low cycles then ready; w >= WL means the wait never ends and times out.
  function automatic bit mem_phase(input logic [3:0] st, input logic [5:0] op, input int w);
    if (w >= WL) begin
      for (int i = 0; i < WL; i++) push(st, op, 1'b0, 1'b0);
      push(S_IDLE, 6'd0, rbit(), 1'b1);
      return 1'b0;
    end
    for (int i = 0; i < w; i++) push(st, op, 1'b0, 1'b0);
    push(st, op, 1'b1, 1'b0);
    return 1'b1;
  endfunction

  function automatic void build_instr(input logic [5:0] op, input int wf, input int wm);
    if (!mem_phase(S_FETCH, op, wf)) return;
    push(S_DECODE, op, rbit(), 1'b0);
    case (op)
      6'd0: begin push(S_EXEC, op, rbit(), 1'b0); push(S_RWB, op, rbit(), 1'b0); end
      6'd2: push(S_JUMP, op, rbit(), 1'b0);
      6'd4, 6'd5: push(S_BRANCH, op, rbit(), 1'b0);
      6'd8: begin push(S_ADDIEX, op, rbit(), 1'b0); push(S_ADDIWB, op, rbit(), 1'b0); end
      6'd35: begin
        push(S_MEMADR, op, rbit(), 1'b0);
        if (mem_phase(S_MEMRD, op, wm)) push(S_MEMWB, op, rbit(), 1'b0);
      end
      6'd43: begin
        push(S_MEMADR, op, rbit(), 1'b0);
        void'(mem_phase(S_MEMWR, op, wm));
      end
      default: pend_ill = 1'b1;
    endcase
  endfunction

  // Control word each state must present, read straight from the state table.
  function automatic logic [18:0] exp_out(input step_t s);
    logic pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca} = '0;
    srcb = 2'd0; aluop = 2'd0; pcsrc = 2'd0;
    case (s.st)
      S_FETCH:  begin mrd = 1'b1; srcb = 2'd1; irw = s.mr; pcw = s.mr; end
      S_DECODE: srcb = 2'd3;
      S_MEMADR: begin srca = 1'b1; srcb = 2'd2; end
      S_MEMRD:  begin mrd = 1'b1; iord = 1'b1; end
      S_MEMWB:  begin rw = 1'b1; m2r = 1'b1; end
      S_MEMWR:  begin mwr = 1'b1; iord = 1'b1; end
      S_EXEC:   begin srca = 1'b1; aluop = 2'd2; end
      S_RWB:    begin rw = 1'b1; rdst = 1'b1; end
      S_BRANCH: begin srca = 1'b1; aluop = 2'd1; pcwc = 1'b1; pcsrc = 2'd1; bne = (s.op == 6'd5); end
      S_ADDIEX: begin srca = 1'b1; srcb = 2'd2; end
      S_ADDIWB: rw = 1'b1;
      S_JUMP:   begin pcw = 1'b1; pcsrc = 2'd2; end
      default: ;
    endcase
    return {pcw, pcwc, bne, iord, mrd, mwr, irw, m2r, rdst, rw, srca, srcb, aluop, pcsrc, s.ill, s.tmo};
  endfunction

  function automatic logic [18:0] obs_out();
    return {bus.PCWrite, bus.PCWriteCond, bus.BranchNE, bus.IorD, bus.MemRead, bus.MemWrite,
            bus.IRWrite, bus.MemToReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
            bus.ALUOp, bus.PCSource, bus.Illegal, bus.MemTimeout};
  endfunction

  task automatic check_step(input step_t s);
    logic [18:0] e;
    logic [18:0] o;
    e = exp_out(s);
    o = obs_out();
    checks++;
    assert (bus.State === s.st) else begin
      errors++;
      $error("FAIL state op=%0d mr=%0b observed=%0d expected=%0d", s.op, s.mr, bus.State, s.st);
    end
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL outputs state=%0d op=%0d mr=%0b observed=%05h expected=%05h", s.st, s.op, s.mr, o, e);
    end
  endtask

  task automatic run_queue();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      bus.Op = s.op;
      bus.MemReady = s.mr;
      @(negedge clock);
      check_step(s);
      @(posedge clock);
      #1;
    end
  endtask

  function automatic logic [5:0] rand_op();
    logic [5:0] op;
    int k;
    k = $urandom_range(0, 7);
    case (k)
      0: op = 6'd0;  1: op = 6'd2;  2: op = 6'd4;  3: op = 6'd5;
      4: op = 6'd8;  5: op = 6'd35; 6: op = 6'd43;
      default: begin
        op = 6'($urandom_range(0, 63));
        while (op == 6'd0 || op == 6'd2 || op == 6'd4 || op == 6'd5 ||
               op == 6'd8 || op == 6'd35 || op == 6'd43)
          op = 6'($urandom_range(0, 63));
      end
    endcase
    return op;
  endfunction

  function automatic int rand_wait();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    if (r == 7) return WL - 1;
    if (r == 8) return WL;
    return WL + 5;
  endfunction

  initial begin
    step_t idle_s;
    bus.Op = 6'd0;
    bus.MemReady = 1'b0;

    // Held in reset across edges: IDLE with every output low.
    #22;
    idle_s.st = S_IDLE; idle_s.op = 6'd0; idle_s.mr = 1'b0; idle_s.ill = 1'b0; idle_s.tmo = 1'b0;
    check_step(idle_s);
    @(posedge clock); #1;
    reset = 1'b1;

    // Directed: R, LW with 3 waits, BNE, BEQ, J, FETCH timeout, wait boundary, illegal, ADDI.
    push(S_IDLE, 6'd0, 1'b1, 1'b0);
    build_instr(6'd0, 0, 0);
    build_instr(6'd35, 0, 3);
    build_instr(6'd5, 0, 0);
    build_instr(6'd4, 0, 0);
    build_instr(6'd2, 0, 0);
    build_instr(6'd0, WL, 0);
    build_instr(6'd8, WL - 1, 0);
    build_instr(6'h3F, 0, 0);
    build_instr(6'd8, 0, 0);
    build_instr(6'd35, 0, WL);
    build_instr(6'd43, 1, WL - 1);
    run_queue();

    // Randomised instruction stream with random wait profiles.
    for (int n = 0; n < 80; n++) begin
      build_instr(rand_op(), rand_wait(), rand_wait());
      run_queue();
    end
    build_instr(6'd2, 0, 0);
    run_queue();

    // SW stalled in MEMWR, then reset asserted mid-cycle.
    push(S_FETCH, 6'd43, 1'b1, 1'b0);
    push(S_DECODE, 6'd43, 1'b1, 1'b0);
    push(S_MEMADR, 6'd43, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) push(S_MEMWR, 6'd43, 1'b0, 1'b0);
    run_queue();
    checks++;
    assert (bus.MemWrite === 1'b1) else begin
      errors++;
      $error("FAIL memwr_before_reset observed=%0b expected=1", bus.MemWrite);
    end
    reset = 1'b0;
    #1;
    checks++;
    assert (bus.MemWrite === 1'b0) else begin
      errors++;
      $error("FAIL memwr_on_reset observed=%0b expected=0", bus.MemWrite);
    end
    checks++;
    assert (bus.State === S_IDLE) else begin
      errors++;
      $error("FAIL state_on_reset observed=%0d expected=0", bus.State);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    pend_ill = 1'b0;
    push(S_IDLE, 6'd0, 1'b0, 1'b0);
    build_instr(6'd43, 0, 0);
    build_instr(6'd0, 0, 0);
    run_queue();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
